axi_rd_arbiter: RTL
===================

# axi_rd_arbiter

Read-channel arbiter between the instruction-cache miss FSM and the data-cache miss FSM and the single AXI4 read master port. It accepts one cache-line burst request at a time from either cache, issues one INCR burst on AR, and steers the R beats back to the requesting cache. Sits directly downstream of the icache `i_ar*`/`i_r*` port and upstream of the AXI interconnect. Single outstanding transaction; no write channels.

## Interface
- `ID_I`, default 4'd0: ARID used for icache bursts.
- `ID_D`, default 4'd1: ARID used for dcache bursts.
- `LINE_BEATS`, default 4: beats per line (16-byte line, 32-bit data).
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `i_arvalid`, `i_araddr`  in  1, 32  icache line request and line-aligned address.
- `i_arready`  out  1  icache request accepted.
- `i_rvalid`, `i_rlast`  out  1, 1  icache beat valid, last beat.
- `i_rdata`  out  32  icache beat data.
- `i_rready`  in  1  icache accepts beat.
- `d_arvalid`, `d_araddr`, `d_arready`, `d_rvalid`, `d_rlast`, `d_rdata`, `d_rready`: same as the icache set, dcache side.
- `arvalid`  out  1; `araddr`  out  32; `arid`  out  4; `arlen`  out  8; `arsize`  out  3; `arburst`  out  2; `arready`  in  1: AXI AR channel.
- `rvalid`, `rlast`  in  1, 1; `rdata`  in  32; `rresp`  in  2; `rid`  in  4; `rready`  out  1: AXI R channel.
- `rd_err`  out  1  sticky protocol/response error flag.

## Operation
- States: IDLE, AR, R.
- IDLE: if only one of `i_arvalid`/`d_arvalid` is high, grant it. If both are high, grant the cache that was not granted last (round-robin `last_d` bit; reset value 0, so dcache wins the first tie). On grant, register `owner`, `araddr` (requester address with [3:0] forced to 0), and `arid`; go to AR.
- AR: `arvalid`=1. On `arready`, pulse the owner's `*_arready`=1 in the same cycle (combinational from `arready`), clear the beat counter, and go to R. The non-owner's `*_arready` is always 0.
- R: `rready` = owner's `*_rready`. Owner's `*_rvalid`/`*_rdata`/`*_rlast` = `rvalid`/`rdata`/`rlast`; non-owner's `*_rvalid`=0 and `*_rlast`=0. Beat counter (2 bits for default) increments on each `rvalid&&rready`. On a handshake with `rlast`=1, update `last_d`=(owner==D) and go to IDLE.
- Constants: `arlen`=LINE_BEATS-1 (8'd3), `arsize`=3'b010, `arburst`=2'b01.
- `rd_err` is set on any R handshake with `rresp`!=0, `rid`!=`arid`, `rlast`=1 while beat count != LINE_BEATS-1, or `rlast`=0 while beat count == LINE_BEATS-1. It clears only on `rst`. Data is still forwarded on an error; the burst ends on bus `rlast` only.
- Requests that arrive while not in IDLE are held by the requester (its `*_arvalid` stays high) and are evaluated on return to IDLE.

## Timing
- Reset values: `arvalid`=0, `araddr`=0, `arid`=0, `rready`=0, all `*_arready`/`*_rvalid`/`*_rlast`=0, `*_rdata`=0, `rd_err`=0, state IDLE, `last_d`=0.
- Request high in IDLE at cycle N gives `arvalid`=1 at N+1. The minimum AR occupancy is 1 cycle.
- `araddr`/`arid` are stable from AR entry until the `arready` handshake; `arvalid` is never withdrawn before `arready`.
- The R path is combinational pass-through with 0 added latency. Backpressure propagates combinationally through `rready`.
- After the last beat, IDLE is entered the next cycle. The minimum gap between two bursts' `arvalid` is 1 IDLE cycle.
- `rst` mid-burst returns to IDLE immediately and drops `arvalid`/`rready`. Remaining bus beats are not drained (the system reset covers the interconnect).

## Test plan
- Icache only: `i_araddr`=0x1C00_0034, `arready` after 2 cycles, 4 beats 0xA0..0xA3 -> `araddr`=0x1C00_0030, `arid`=0, `arlen`=3, `i_arready` pulses once, `i_rdata` is A0..A3 with `i_rlast` on beat 3, `d_rvalid` stays 0, `rd_err`=0.
- Simultaneous requests from reset: i=0x100, d=0x200 -> dcache is served first (`arid`=1, 0x200), then icache (0x100). On the next simultaneous pair, icache is served first.
- Backpressure: `i_rready` low for 3 cycles mid-burst -> `rready` low for the same cycles, no beat lost or duplicated, 4 handshakes total.
- Error cases: `rresp`=2'b10 on beat 1 -> `rd_err`=1 and stays 1 after the burst. `rlast` on beat 2 -> `rd_err`=1, return to IDLE.
- Reset during R after 2 beats -> all outputs reach their reset values the same cycle. A new icache request is then accepted normally.

Source files
------------

// File: rtl/axi_rd_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_rd_arbiter_if
// Description : Signal bundle for the icache/dcache read-request ports, the
//               shared AXI4 AR/R channels and the sticky error flag.
//               "master" is the arbiter's view; "slave" is the view of the
//               surrounding caches and interconnect.
// Revision    : 1.0  initial release
// ============================================================================
interface axi_rd_arbiter_if;

  // icache side
  logic        i_arvalid;
  logic [31:0] i_araddr;
  logic        i_arready;
  logic        i_rvalid;
  logic        i_rlast;
  logic [31:0] i_rdata;
  logic        i_rready;

  // dcache side
  logic        d_arvalid;
  logic [31:0] d_araddr;
  logic        d_arready;
  logic        d_rvalid;
  logic        d_rlast;
  logic [31:0] d_rdata;
  logic        d_rready;

  // AXI AR channel
  logic        arvalid;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arready;

  // AXI R channel
  logic        rvalid;
  logic        rlast;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [3:0]  rid;
  logic        rready;

  // sticky protocol / response error
  logic        rd_err;

  modport master (
    input  i_arvalid, i_araddr, i_rready,
    input  d_arvalid, d_araddr, d_rready,
    input  arready,
    input  rvalid, rlast, rdata, rresp, rid,
    output i_arready, i_rvalid, i_rlast, i_rdata,
    output d_arready, d_rvalid, d_rlast, d_rdata,
    output arvalid, araddr, arid, arlen, arsize, arburst,
    output rready,
    output rd_err
  );

  modport slave (
    output i_arvalid, i_araddr, i_rready,
    output d_arvalid, d_araddr, d_rready,
    output arready,
    output rvalid, rlast, rdata, rresp, rid,
    input  i_arready, i_rvalid, i_rlast, i_rdata,
    input  d_arready, d_rvalid, d_rlast, d_rdata,
    input  arvalid, araddr, arid, arlen, arsize, arburst,
    input  rready,
    input  rd_err
  );

endinterface
`default_nettype wire

// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axi_rd_arbiter
// Description : Single-outstanding AXI4 read arbiter between the icache and
//               dcache miss FSMs. Grants one line request (round-robin on a
//               tie), issues one INCR burst on AR and steers the R beats back
//               to the owner combinationally. Flags response/ID/length
//               errors in a sticky rd_err bit.
// Revision    : 1.0  initial release
// ============================================================================
module axi_rd_arbiter #(
  parameter logic [3:0]  ID_I       = 4'd0,
  parameter logic [3:0]  ID_D       = 4'd1,
  parameter int unsigned LINE_BEATS = 4
) (
  input  wire logic         clk,
  input  wire logic         rst,
  axi_rd_arbiter_if.master  bus
);

  // Beat counter width; a single-beat line still needs a 1-bit counter.
  localparam int unsigned          c_CNT_W     = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam logic [c_CNT_W-1:0]   c_LAST_BEAT = c_CNT_W'(LINE_BEATS - 1);
  localparam logic [7:0]           c_ARLEN     = 8'(LINE_BEATS - 1);
  localparam logic [2:0]           c_ARSIZE    = 3'b010;   // 4-byte beats
  localparam logic [1:0]           c_ARBURST   = 2'b01;    // INCR
  localparam logic [31:0]          c_LINE_MASK = 32'hFFFF_FFF0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2
  } state_t;

  state_t             state_q,  state_d;
  logic               owner_q,  owner_d;    // 1 = dcache owns the bus
  logic [31:0]        araddr_q, araddr_d;
  logic [3:0]         arid_q,   arid_d;
  logic               last_d_q, last_d_d;   // dcache won the previous grant
  logic [c_CNT_W-1:0] beat_q,   beat_d;
  logic               rd_err_q, rd_err_d;

  logic               w_in_ar;
  logic               w_in_r;
  logic               w_rready;
  logic               w_hs;
  logic               w_pick_d;
  logic [31:0]        w_req_addr;
  logic               w_beat_err;

  assign w_in_ar  = (state_q == S_AR);
  assign w_in_r   = (state_q == S_R);

  // Backpressure from the owning cache goes straight to the bus.
  assign w_rready = w_in_r && (owner_q ? bus.d_rready : bus.i_rready);
  assign w_hs     = bus.rvalid && w_rready;

  // A beat is bad on an error response, a foreign ID, or rlast out of place.
  assign w_beat_err = (bus.rresp != 2'b00) ||
                      (bus.rid != arid_q) ||
                      (bus.rlast != (beat_q == c_LAST_BEAT));

  // Next-state, grant decision and datapath register updates.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    araddr_d   = araddr_q;
    arid_d     = arid_q;
    last_d_d   = last_d_q;
    beat_d     = beat_q;
    rd_err_d   = rd_err_q;
    w_pick_d   = 1'b0;
    w_req_addr = bus.i_araddr;

    case (state_q)
      S_IDLE: begin
        if (bus.i_arvalid || bus.d_arvalid) begin
          // On a tie the cache that lost last time wins.
          w_pick_d   = bus.d_arvalid && (!bus.i_arvalid || !last_d_q);
          w_req_addr = w_pick_d ? bus.d_araddr : bus.i_araddr;
          owner_d    = w_pick_d;
          araddr_d   = w_req_addr & c_LINE_MASK;
          arid_d     = w_pick_d ? ID_D : ID_I;
          state_d    = S_AR;
        end
      end
      S_AR: begin
        if (bus.arready) begin
          beat_d  = '0;
          state_d = S_R;
        end
      end
      S_R: begin
        if (w_hs) begin
          beat_d = beat_q + 1'b1;
          if (w_beat_err) begin
            rd_err_d = 1'b1;
          end
          // The burst ends on the bus rlast even if it came early or late.
          if (bus.rlast) begin
            last_d_d = owner_q;
            state_d  = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any burst in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      araddr_q <= 32'h0;
      arid_q   <= 4'h0;
      last_d_q <= 1'b0;
      beat_q   <= '0;
      rd_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      araddr_q <= araddr_d;
      arid_q   <= arid_d;
      last_d_q <= last_d_d;
      beat_q   <= beat_d;
      rd_err_q <= rd_err_d;
    end
  end

  // AR channel: address and ID are held from AR entry until the handshake.
  assign bus.arvalid = w_in_ar;
  assign bus.araddr  = araddr_q;
  assign bus.arid    = arid_q;
  assign bus.arlen   = c_ARLEN;
  assign bus.arsize  = c_ARSIZE;
  assign bus.arburst = c_ARBURST;

  // Request acceptance is a combinational echo of arready to the owner only.
  assign bus.i_arready = w_in_ar && !owner_q && bus.arready;
  assign bus.d_arready = w_in_ar &&  owner_q && bus.arready;

  // R channel steering: zero-latency pass-through to the owner, zero elsewhere.
  assign bus.rready   = w_rready;
  assign bus.i_rvalid = w_in_r && !owner_q && bus.rvalid;
  assign bus.i_rlast  = w_in_r && !owner_q && bus.rlast;
  assign bus.i_rdata  = (w_in_r && !owner_q) ? bus.rdata : 32'h0;
  assign bus.d_rvalid = w_in_r &&  owner_q && bus.rvalid;
  assign bus.d_rlast  = w_in_r &&  owner_q && bus.rlast;
  assign bus.d_rdata  = (w_in_r &&  owner_q) ? bus.rdata : 32'h0;

  assign bus.rd_err = rd_err_q;

endmodule
`default_nettype wire
